// File: rtl/ram_prog_ctrl_if.sv
// Signal bundle between the SAP memory controller, the program loader,
// the CPU (MAR/bus side) and the 16x8 program/data memory.
interface ram_prog_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // Byte-serial program loader
    logic              prog_start;
    logic [ADDR_W:0]   prog_len;
    logic [DATA_W-1:0] prog_data;
    logic              prog_valid;
    logic              prog_ready;
    logic              prog_busy;
    logic              prog_done;
    logic              prog_err;

    // CPU side
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_low_load;
    logic              cpu_low_o_en;
    logic              cpu_grant;

    // Memory pins
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_low_load;
    logic              mem_low_o_en;

    // The controller sees loader and CPU requests and drives the memory pins.
    modport slave (
        input  prog_start, prog_len, prog_data, prog_valid,
        input  cpu_addr, cpu_data, cpu_low_load, cpu_low_o_en,
        output prog_ready, prog_busy, prog_done, prog_err, cpu_grant,
        output mem_addr, mem_data, mem_low_load, mem_low_o_en
    );

    // The surrounding system drives requests and observes the controller.
    modport master (
        output prog_start, prog_len, prog_data, prog_valid,
        output cpu_addr, cpu_data, cpu_low_load, cpu_low_o_en,
        input  prog_ready, prog_busy, prog_done, prog_err, cpu_grant,
        input  mem_addr, mem_data, mem_low_load, mem_low_o_en
    );
endinterface

// File: rtl/ram_prog_ctrl.sv
// SAP program/data memory controller. Loads a byte stream from the
// front-panel loader into consecutive addresses starting at 0, then hands
// the memory pins over to the CPU as a combinational pass-through.
module ram_prog_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic           clk,
    input  logic           low_clr,
    ram_prog_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0]   len_r, len_nxt;
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic [DATA_W-1:0] data_r, data_nxt;
    logic              done_r, done_nxt;
    logic              err_r, err_nxt;

    logic              len_ok;
    logic              last_word;

    assign len_ok    = (bus.prog_len != '0) && (bus.prog_len <= LEN_MAX);
    assign last_word = ({1'b0, wr_ptr} == (len_r - LEN_ONE));

    // Next-state logic: sequences start/accept/write and handles restarts from RUN.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        len_nxt    = len_r;
        addr_nxt   = addr_r;
        data_nxt   = data_r;
        done_nxt   = done_r;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.prog_start) begin
                    if (len_ok) begin
                        len_nxt    = bus.prog_len;
                        wr_ptr_nxt = '0;
                        state_nxt  = LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.prog_valid) begin
                    addr_nxt  = wr_ptr;
                    data_nxt  = bus.prog_data;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    done_nxt  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    wr_ptr_nxt = wr_ptr + ADDR_W'(1);
                    state_nxt  = LOAD;
                end
            end
            RUN: begin
                if (bus.prog_start) begin
                    if (len_ok) begin
                        len_nxt    = bus.prog_len;
                        wr_ptr_nxt = '0;
                        done_nxt   = 1'b0;
                        state_nxt  = LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; low_clr aborts any load immediately.
    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            state  <= IDLE;
            wr_ptr <= '0;
            len_r  <= '0;
            addr_r <= '0;
            data_r <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            len_r  <= len_nxt;
            addr_r <= addr_nxt;
            data_r <= data_nxt;
            done_r <= done_nxt;
            err_r  <= err_nxt;
        end
    end

    // Output mux: CPU owns the pins only in RUN, otherwise the loader's registered write.
    always_comb begin
        bus.prog_ready = (state == LOAD);
        bus.prog_busy  = (state == LOAD) || (state == WRITE);
        bus.prog_done  = done_r;
        bus.prog_err   = err_r;
        bus.cpu_grant  = (state == RUN);
        bus.mem_addr     = addr_r;
        bus.mem_data     = data_r;
        bus.mem_low_load = (state != WRITE);
        bus.mem_low_o_en = 1'b1;
        if (state == RUN) begin
            bus.mem_addr     = bus.cpu_addr;
            bus.mem_data     = bus.cpu_data;
            bus.mem_low_load = bus.cpu_low_load;
            bus.mem_low_o_en = bus.cpu_low_o_en;
        end
    end

endmodule

// File: tb/tb_ram_prog_ctrl.sv
// Directed testbench for ram_prog_ctrl with a behavioural 16x8 RAM on the
// memory pins and a log of every write strobe the RAM sees.
module tb_ram_prog_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic low_clr;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem_model [DEPTH];
    int         wr_log_q [$];
    logic [7:0] t1_bytes [3] = '{8'hA1, 8'hB2, 8'hC3};

    ram_prog_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_prog_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .low_clr (low_clr),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // RAM model: captures on the rising edge while low_load is asserted, logs {addr,data}.
    always @(posedge clk) begin
        if (bus.mem_low_load == 1'b0) begin
            mem_model[bus.mem_addr] <= bus.mem_data;
            wr_log_q.push_back((int'(bus.mem_addr) << 8) | int'(bus.mem_data));
        end
    end

    // Safety net so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] ram_read();
        return bus.mem_low_o_en ? 8'h00 : mem_model[bus.mem_addr];
    endfunction

    task automatic check_output(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [ADDR_W:0] len);
        bus.prog_start = 1'b1;
        bus.prog_len   = len;
        step();
        bus.prog_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ready"}, 32'(bus.prog_ready), 0);
        check_output({tag, "_busy"},  32'(bus.prog_busy),  0);
        check_output({tag, "_done"},  32'(bus.prog_done),  0);
        check_output({tag, "_err"},   32'(bus.prog_err),   0);
        check_output({tag, "_grant"}, 32'(bus.cpu_grant),  0);
        check_output({tag, "_addr"},  32'(bus.mem_addr),   0);
        check_output({tag, "_data"},  32'(bus.mem_data),   0);
        check_output({tag, "_load"},  32'(bus.mem_low_load), 1);
        check_output({tag, "_oen"},   32'(bus.mem_low_o_en), 1);
    endtask

    initial begin
        int n;
        int cyc;
        logic hs;

        for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
        low_clr          = 1'b0;
        bus.prog_start   = 1'b0;
        bus.prog_len     = '0;
        bus.prog_data    = '0;
        bus.prog_valid   = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_data     = '0;
        bus.cpu_low_load = 1'b1;
        bus.cpu_low_o_en = 1'b1;

        // Reset values
        #2;
        check_reset_outputs("rst");
        step();
        step();
        low_clr = 1'b1;
        step();

        // Load three bytes with valid held high
        bus.prog_valid = 1'b1;
        bus.prog_data  = t1_bytes[0];
        apply_stimulus(5'd3);
        check_output("t1_busy",  32'(bus.prog_busy),  1);
        check_output("t1_ready", 32'(bus.prog_ready), 1);
        check_output("t1_load_idle", 32'(bus.mem_low_load), 1);
        for (int i = 0; i < 3; i++) begin
            bus.prog_data = t1_bytes[i];
            step();
            check_output("t1_wr_strobe", 32'(bus.mem_low_load), 0);
            check_output("t1_wr_addr",   32'(bus.mem_addr), i);
            check_output("t1_wr_data",   32'(bus.mem_data), 32'(t1_bytes[i]));
            check_output("t1_wr_ready",  32'(bus.prog_ready), 0);
            step();
        end
        bus.prog_valid = 1'b0;
        check_output("t1_done",  32'(bus.prog_done), 1);
        check_output("t1_grant", 32'(bus.cpu_grant), 1);
        check_output("t1_busy_end", 32'(bus.prog_busy), 0);
        for (int i = 0; i < 3; i++) begin
            bus.cpu_addr     = ADDR_W'(i);
            bus.cpu_low_o_en = 1'b0;
            #1;
            check_output("t1_cpu_oen",  32'(bus.mem_low_o_en), 0);
            check_output("t1_cpu_read", 32'(ram_read()), 32'(t1_bytes[i]));
            bus.cpu_low_o_en = 1'b1;
            step();
        end

        // Full 16-word load with valid toggling every cycle
        wr_log_q.delete();
        apply_stimulus(5'd16);
        check_output("t2_grant_drop", 32'(bus.cpu_grant), 0);
        n   = 0;
        cyc = 0;
        while (!bus.prog_done && cyc < 200) begin
            bus.prog_valid = cyc[0];
            bus.prog_data  = 8'h30 + n[7:0];
            #1;
            hs = bus.prog_valid && bus.prog_ready;
            step();
            if (hs) n++;
            cyc++;
        end
        bus.prog_valid = 1'b0;
        check_output("t2_done",   32'(bus.prog_done), 1);
        check_output("t2_nwr",    wr_log_q.size(), 16);
        for (int k = 0; k < 16; k++) begin
            check_output("t2_wr", (k < wr_log_q.size()) ? wr_log_q[k] : -1, (k << 8) | (8'h30 + k));
        end
        check_output("t2_grant", 32'(bus.cpu_grant), 1);

        // Illegal lengths from IDLE
        low_clr = 1'b0;
        step();
        low_clr = 1'b1;
        step();
        wr_log_q.delete();
        apply_stimulus(5'd0);
        check_output("t3_err0",   32'(bus.prog_err),  1);
        check_output("t3_busy0",  32'(bus.prog_busy), 0);
        check_output("t3_grant0", 32'(bus.cpu_grant), 0);
        step();
        check_output("t3_err0_clr", 32'(bus.prog_err), 0);
        apply_stimulus(5'd17);
        check_output("t3_err17",  32'(bus.prog_err),  1);
        check_output("t3_load17", 32'(bus.mem_low_load), 1);
        step();
        check_output("t3_err17_clr", 32'(bus.prog_err), 0);
        check_output("t3_nwr", wr_log_q.size(), 0);

        // CPU write in RUN, then reload one byte over the top
        bus.prog_valid = 1'b1;
        bus.prog_data  = 8'h77;
        apply_stimulus(5'd1);
        step();
        step();
        bus.prog_valid = 1'b0;
        check_output("t4_grant", 32'(bus.cpu_grant), 1);
        bus.cpu_addr     = 4'd9;
        bus.cpu_data     = 8'h5E;
        bus.cpu_low_load = 1'b0;
        #1;
        check_output("t4_cpu_strobe", 32'(bus.mem_low_load), 0);
        check_output("t4_cpu_addr",   32'(bus.mem_addr), 9);
        check_output("t4_cpu_data",   32'(bus.mem_data), 32'h5E);
        step();
        bus.cpu_low_load = 1'b1;
        bus.cpu_low_o_en = 1'b0;
        bus.prog_valid   = 1'b1;
        bus.prog_data    = 8'h11;
        bus.prog_start   = 1'b1;
        bus.prog_len     = 5'd1;
        #1;
        check_output("t4_grant_start", 32'(bus.cpu_grant), 1);
        step();
        bus.prog_start = 1'b0;
        check_output("t4_grant_drop", 32'(bus.cpu_grant), 0);
        check_output("t4_oen_load",   32'(bus.mem_low_o_en), 1);
        check_output("t4_ld_load",    32'(bus.mem_low_load), 1);
        step();
        check_output("t4_wr_strobe", 32'(bus.mem_low_load), 0);
        check_output("t4_wr_addr",   32'(bus.mem_addr), 0);
        check_output("t4_wr_data",   32'(bus.mem_data), 32'h11);
        check_output("t4_oen_write", 32'(bus.mem_low_o_en), 1);
        step();
        bus.prog_valid   = 1'b0;
        bus.cpu_low_o_en = 1'b1;
        check_output("t4_mem0", 32'(mem_model[0]), 32'h11);
        check_output("t4_mem9", 32'(mem_model[9]), 32'h5E);

        // Reset during the write of the second byte
        bus.prog_valid = 1'b1;
        bus.prog_data  = 8'hD1;
        apply_stimulus(5'd3);
        step();
        step();
        bus.prog_data = 8'hD2;
        step();
        check_output("t5_wr1_addr", 32'(bus.mem_addr), 1);
        low_clr = 1'b0;
        #1;
        check_reset_outputs("t5");
        step();
        check_output("t5_mem1_kept", 32'(mem_model[1]), 32'h31);
        check_output("t5_mem0",      32'(mem_model[0]), 32'hD1);
        low_clr       = 1'b1;
        bus.prog_data = 8'hE0;
        apply_stimulus(5'd2);
        step();
        check_output("t5_re_addr", 32'(bus.mem_addr), 0);
        check_output("t5_re_data", 32'(bus.mem_data), 32'hE0);
        step();
        bus.prog_data = 8'hE1;
        step();
        check_output("t5_re_addr1", 32'(bus.mem_addr), 1);
        step();
        bus.prog_valid = 1'b0;
        check_output("t5_done", 32'(bus.prog_done), 1);

        // prog_start during LOAD is ignored
        wr_log_q.delete();
        apply_stimulus(5'd4);
        bus.prog_valid = 1'b1;
        bus.prog_data  = 8'hF0;
        step();
        step();
        bus.prog_valid = 1'b0;
        apply_stimulus(5'd2);
        check_output("t6_err_legal", 32'(bus.prog_err),  0);
        check_output("t6_busy",      32'(bus.prog_busy), 1);
        apply_stimulus(5'd0);
        check_output("t6_err_bad",   32'(bus.prog_err),  0);
        n   = 1;
        cyc = 0;
        bus.prog_valid = 1'b1;
        while (!bus.prog_done && cyc < 50) begin
            bus.prog_data = 8'hF0 + n[7:0];
            #1;
            hs = bus.prog_ready;
            step();
            if (hs) n++;
            cyc++;
        end
        bus.prog_valid = 1'b0;
        check_output("t6_done", 32'(bus.prog_done), 1);
        check_output("t6_nwr",  wr_log_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check_output("t6_wr", (k < wr_log_q.size()) ? wr_log_q[k] : -1, (k << 8) | (8'hF0 + k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
